// File: rtl/pipe_slice_if.sv
// rtl/pipe_slice_if.sv - valid/ready stream bundle used on both sides of pipe_slice
interface pipe_slice_if #(
  parameter int DATA_WIDTH = 256
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_slice.sv
// rtl/pipe_slice.sv - STAGES-deep valid/ready register-slice chain (FWD/BWD/FULL); PIPE_SLICE_STATS_EN adds counters
module pipe_slice #(
  parameter int DATA_WIDTH = 256,
  parameter int STAGES     = 2,
  parameter int MODE       = 2
) (
  input  logic         clk,
  input  logic         reset,
  pipe_slice_if.slave  pipe_in,
  pipe_slice_if.master pipe_out
`ifdef PIPE_SLICE_STATS_EN
  ,
  output logic [31:0]  stat_xfer_cnt,
  output logic [31:0]  stat_stall_cnt
`else
`endif
);

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("pipe_slice: MODE must be 0, 1 or 2");
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("pipe_slice: STAGES must be in 1..8");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("pipe_slice: DATA_WIDTH must be >= 1");
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    // Slice 0 takes the upstream port, later slices take the previous slice's output.
    if (i == 0) begin : g_src_port
      assign in_valid = pipe_in.valid;
      assign in_data  = pipe_in.data;
    end else begin : g_src_chain
      assign in_valid = g_stage[i-1].out_valid;
      assign in_data  = g_stage[i-1].out_data;
    end

    // The last slice sees downstream ready, earlier slices see the next slice's in_ready.
    if (i == STAGES - 1) begin : g_snk_port
      assign out_ready = pipe_out.ready;
    end else begin : g_snk_chain
      assign out_ready = g_stage[i+1].in_ready;
    end

    if (MODE == 0) begin : g_fwd
      logic                  fwd_valid;
      logic [DATA_WIDTH-1:0] fwd_data;

      assign in_ready  = !fwd_valid || out_ready;
      assign out_valid = fwd_valid;
      assign out_data  = fwd_data;

      // Load a new beat whenever there is room, otherwise drain on downstream ready.
      always_ff @(posedge clk) begin
        if (!reset) begin
          fwd_valid <= 1'b0;
          fwd_data  <= '0;
        end else if (in_valid && in_ready) begin
          fwd_valid <= 1'b1;
          fwd_data  <= in_data;
        end else if (out_ready) begin
          fwd_valid <= 1'b0;
        end
      end
    end else if (MODE == 1) begin : g_bwd
      logic                  skid_valid;
      logic [DATA_WIDTH-1:0] skid_data;

      assign in_ready  = !skid_valid;
      assign out_valid = in_valid || skid_valid;
      assign out_data  = skid_valid ? skid_data : in_data;

      // Park an accepted beat that downstream refused; hand it over once downstream is ready.
      always_ff @(posedge clk) begin
        if (!reset) begin
          skid_valid <= 1'b0;
          skid_data  <= '0;
        end else if (skid_valid) begin
          if (out_ready) begin
            skid_valid <= 1'b0;
          end
        end else if (in_valid && !out_ready) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
        end
      end
    end else begin : g_full
      logic [1:0]            count;
      logic                  rd_ptr;
      logic                  wr_ptr;
      logic [DATA_WIDTH-1:0] entry [0:1];
      logic                  push;
      logic                  pop;

      assign in_ready  = (count != 2'd2);
      assign out_valid = (count != 2'd0);
      assign out_data  = entry[rd_ptr];
      assign push      = in_valid && in_ready;
      assign pop       = out_valid && out_ready;

      // Two-entry ring: push writes at wr_ptr, pop advances rd_ptr, count tracks occupancy.
      always_ff @(posedge clk) begin
        if (!reset) begin
          count    <= 2'd0;
          rd_ptr   <= 1'b0;
          wr_ptr   <= 1'b0;
          entry[0] <= '0;
          entry[1] <= '0;
        end else begin
          if (push) begin
            entry[wr_ptr] <= in_data;
            wr_ptr        <= ~wr_ptr;
          end
          if (pop) begin
            rd_ptr <= ~rd_ptr;
          end
          if (push && !pop) begin
            count <= count + 2'd1;
          end else if (pop && !push) begin
            count <= count - 2'd1;
          end
        end
      end
    end
  end

  // Ports are forced idle while reset is low so no stale or pass-through beat escapes.
  assign pipe_in.ready  = reset && g_stage[0].in_ready;
  assign pipe_out.valid = reset && g_stage[STAGES-1].out_valid;
  assign pipe_out.data  = reset ? g_stage[STAGES-1].out_data : '0;

`ifdef PIPE_SLICE_STATS_EN
  // Output transfers wrap, stalled output cycles saturate.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_xfer_cnt  <= 32'd0;
      stat_stall_cnt <= 32'd0;
    end else begin
      if (pipe_out.valid && pipe_out.ready) begin
        stat_xfer_cnt <= stat_xfer_cnt + 32'd1;
      end
      if (pipe_out.valid && !pipe_out.ready && stat_stall_cnt != 32'hFFFF_FFFF) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_pipe_slice.sv
// tb/tb_pipe_slice.sv - directed and random checks of pipe_slice in FWD, BWD and FULL modes
module tb_pipe_slice;
  localparam int W = 16;
  localparam int N_RAND = 10000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_slice_if #(.DATA_WIDTH(W)) p0_in ();
  pipe_slice_if #(.DATA_WIDTH(W)) p0_out ();
  pipe_slice_if #(.DATA_WIDTH(W)) p1_in ();
  pipe_slice_if #(.DATA_WIDTH(W)) p1_out ();
  pipe_slice_if #(.DATA_WIDTH(W)) p2_in ();
  pipe_slice_if #(.DATA_WIDTH(W)) p2_out ();

  pipe_slice #(.DATA_WIDTH(W), .STAGES(3), .MODE(0)) u_fwd (
    .clk(clk), .reset(reset), .pipe_in(p0_in), .pipe_out(p0_out));
  pipe_slice #(.DATA_WIDTH(W), .STAGES(2), .MODE(1)) u_bwd (
    .clk(clk), .reset(reset), .pipe_in(p1_in), .pipe_out(p1_out));
`ifdef PIPE_SLICE_STATS_EN
  logic [31:0] stat_xfer_cnt;
  logic [31:0] stat_stall_cnt;
  pipe_slice #(.DATA_WIDTH(W), .STAGES(2), .MODE(2)) u_full (
    .clk(clk), .reset(reset), .pipe_in(p2_in), .pipe_out(p2_out),
    .stat_xfer_cnt(stat_xfer_cnt), .stat_stall_cnt(stat_stall_cnt));
`else
  pipe_slice #(.DATA_WIDTH(W), .STAGES(2), .MODE(2)) u_full (
    .clk(clk), .reset(reset), .pipe_in(p2_in), .pipe_out(p2_out));
`endif

  logic [W-1:0] rx0[$];
  logic [W-1:0] rx1[$];
  logic [W-1:0] rx2[$];
  int           rx0_cyc[$];
  int           rx1_cyc[$];

  always @(negedge clk) begin
    if (reset && p0_out.valid && p0_out.ready) begin
      rx0.push_back(p0_out.data);
      rx0_cyc.push_back(cyc);
    end
    if (reset && p1_out.valid && p1_out.ready) begin
      rx1.push_back(p1_out.data);
      rx1_cyc.push_back(cyc);
    end
    if (reset && p2_out.valid && p2_out.ready) begin
      rx2.push_back(p2_out.data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic acc;
  int   first_push;
  int   acc_n;
  int   sent;
  int   errs;

  initial begin
    p0_in.valid = 1'b0; p0_in.data = '0; p0_out.ready = 1'b0;
    p1_in.valid = 1'b1; p1_in.data = 16'h003C; p1_out.ready = 1'b0;
    p2_in.valid = 1'b0; p2_in.data = '0; p2_out.ready = 1'b0;

    // reset: ports gated even with a BWD pass-through beat presented
    @(negedge clk);
    check("rst_fwd_rdy", 32'(p0_in.ready), 0);
    check("rst_fwd_vld", 32'(p0_out.valid), 0);
    check("rst_bwd_rdy", 32'(p1_in.ready), 0);
    check("rst_bwd_vld", 32'(p1_out.valid), 0);
    check("rst_bwd_data", 32'(p1_out.data), 0);
    check("rst_full_rdy", 32'(p2_in.ready), 0);
    check("rst_full_vld", 32'(p2_out.valid), 0);
    @(posedge clk); #1;
    p1_in.valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_fwd_rdy", 32'(p0_in.ready), 1);
    check("post_rst_bwd_rdy", 32'(p1_in.ready), 1);
    check("post_rst_full_rdy", 32'(p2_in.ready), 1);
    check("post_rst_full_vld", 32'(p2_out.valid), 0);
    @(posedge clk); #1;

    // FWD, 3 stages: 16 back-to-back beats, latency 3
    p0_out.ready = 1'b1;
    first_push = -100;
    for (int k = 1; k <= 16; k++) begin
      p0_in.valid = 1'b1; p0_in.data = 16'(k);
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) begin
        @(negedge clk);
        acc = p0_in.ready;
        if (k == 1 && acc) first_push = cyc;
        @(posedge clk); #1;
      end
    end
    p0_in.valid = 1'b0;
    for (int t = 0; t < 40 && rx0.size() < 16; t++) @(posedge clk);
    #1;
    check("fwd_count", 32'(rx0.size()), 16);
    check("fwd_latency", (rx0.size() > 0) ? 32'(rx0_cyc[0] - first_push) : 32'hDEAD, 3);
    check("fwd_gapless", (rx0.size() >= 16) ? 32'(rx0_cyc[15] - rx0_cyc[0]) : 32'hDEAD, 15);
    for (int i = 0; i < 16; i++)
      check("fwd_data", (i < rx0.size()) ? 32'(rx0[i]) : 32'hDEAD, 32'(i + 1));

    // FWD: fill under backpressure, then in_ready follows out_ready in the same cycle
    p0_out.ready = 1'b0;
    acc_n = 0;
    for (int t = 0; t < 6; t++) begin
      p0_in.valid = 1'b1; p0_in.data = 16'(16'h0021 + acc_n);
      @(negedge clk);
      if (p0_in.ready) acc_n++;
      @(posedge clk); #1;
    end
    p0_in.valid = 1'b0;
    check("fwd_fill", 32'(acc_n), 3);
    @(negedge clk);
    check("fwd_full_rdy", 32'(p0_in.ready), 0);
    p0_out.ready = 1'b1;
    #1;
    check("fwd_ready_comb", 32'(p0_in.ready), 1);
    for (int t = 0; t < 10 && rx0.size() < 19; t++) @(posedge clk);
    #1;
    check("fwd_drain_count", 32'(rx0.size()), 19);
    check("fwd_drain_last", (rx0.size() >= 19) ? 32'(rx0[18]) : 32'hDEAD, 32'h23);

    // BWD, 2 stages: two beats buffered, third refused, then gapless delivery
    @(posedge clk); #1;
    p1_out.ready = 1'b0;
    p1_in.valid = 1'b1; p1_in.data = 16'h00A0;
    @(negedge clk);
    check("bwd_rdy_a0", 32'(p1_in.ready), 1);
    check("bwd_pass_vld", 32'(p1_out.valid), 1);
    check("bwd_pass_data", 32'(p1_out.data), 32'hA0);
    @(posedge clk); #1;
    p1_in.data = 16'h00A1;
    @(negedge clk);
    check("bwd_rdy_a1", 32'(p1_in.ready), 1);
    @(posedge clk); #1;
    p1_in.data = 16'h00A2;
    @(negedge clk);
    check("bwd_rdy_a2", 32'(p1_in.ready), 0);
    @(posedge clk); #1;
    p1_out.ready = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) begin
      @(negedge clk);
      acc = p1_in.ready;
      @(posedge clk); #1;
    end
    p1_in.valid = 1'b0;
    for (int t = 0; t < 10 && rx1.size() < 3; t++) @(posedge clk);
    #1;
    check("bwd_count", 32'(rx1.size()), 3);
    for (int i = 0; i < 3; i++)
      check("bwd_data", (i < rx1.size()) ? 32'(rx1[i]) : 32'hDEAD, 32'(32'hA0 + i));
    check("bwd_gapless", (rx1.size() >= 3) ? 32'(rx1_cyc[2] - rx1_cyc[0]) : 32'hDEAD, 2);

    // FULL, 2 stages: capacity 4, stall release after one pop
    @(posedge clk); #1;
    p2_out.ready = 1'b0;
    acc_n = 0;
    for (int t = 0; t < 8; t++) begin
      p2_in.valid = 1'b1; p2_in.data = 16'(16'h00C0 + acc_n);
      @(negedge clk);
      if (p2_in.ready) acc_n++;
      @(posedge clk); #1;
    end
    check("full_accepts", 32'(acc_n), 4);
    @(negedge clk);
    check("full_rdy_full", 32'(p2_in.ready), 0);
    @(posedge clk); #1;
    p2_out.ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    p2_out.ready = 1'b0;
    @(negedge clk);
    check("full_rdy_after_out_pop", 32'(p2_in.ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_rdy_after_s0_pop", 32'(p2_in.ready), 1);
    @(posedge clk); #1;
    p2_in.valid = 1'b0;
    p2_out.ready = 1'b1;
    for (int t = 0; t < 12 && rx2.size() < 5; t++) @(posedge clk);
    #1;
    check("full_count", 32'(rx2.size()), 5);
    for (int i = 0; i < 5; i++)
      check("full_data", (i < rx2.size()) ? 32'(rx2[i]) : 32'hDEAD, 32'(32'hC0 + i));

    // FULL random valid/ready at 50%: in order, no loss, no duplicate
    rx2.delete();
    sent = 0;
    p2_in.valid = 1'b0;
    for (int c = 0; c < 60000 && rx2.size() < N_RAND; c++) begin
      if (!p2_in.valid && sent < N_RAND && $urandom_range(0, 1) == 1) begin
        p2_in.valid = 1'b1; p2_in.data = 16'(sent);
      end
      p2_out.ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      acc = p2_in.valid && p2_in.ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        p2_in.valid = 1'b0;
      end
    end
    p2_in.valid = 1'b0;
    p2_out.ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    errs = 0;
    for (int i = 0; i < rx2.size(); i++)
      if (rx2[i] !== 16'(i)) errs++;
    check("rand_count", 32'(rx2.size()), N_RAND);
    check("rand_order_errs", 32'(errs), 0);

    // reset with 3 beats buffered drops them; 0x55 is first out afterwards
    p2_out.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p2_in.valid = 1'b1; p2_in.data = 16'(16'h0011 + k);
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) begin
        @(negedge clk);
        acc = p2_in.ready;
        @(posedge clk); #1;
      end
    end
    p2_in.valid = 1'b0;
    @(negedge clk);
    check("pre_rst_vld", 32'(p2_out.valid), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_vld", 32'(p2_out.valid), 0);
    check("midrst_data", 32'(p2_out.data), 0);
    check("midrst_rdy", 32'(p2_in.ready), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    rx2.delete();
    @(negedge clk);
    check("after_rst_rdy", 32'(p2_in.ready), 1);
    check("after_rst_vld", 32'(p2_out.valid), 0);
    @(posedge clk); #1;
    p2_out.ready = 1'b1;
    p2_in.valid = 1'b1; p2_in.data = 16'h0055;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) begin
      @(negedge clk);
      acc = p2_in.ready;
      @(posedge clk); #1;
    end
    p2_in.valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("after_rst_count", 32'(rx2.size()), 1);
    check("after_rst_first", (rx2.size() > 0) ? 32'(rx2[0]) : 32'hDEAD, 32'h55);

`ifdef PIPE_SLICE_STATS_EN
    // statistics: 5 transfers then 7 stalled cycles
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("stat_rst_xfer", stat_xfer_cnt, 0);
    check("stat_rst_stall", stat_stall_cnt, 0);
    p2_out.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      p2_in.valid = 1'b1; p2_in.data = 16'(16'h0060 + k);
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) begin
        @(negedge clk);
        acc = p2_in.ready;
        @(posedge clk); #1;
      end
    end
    p2_in.valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    p2_out.ready = 1'b0;
    p2_in.valid = 1'b1; p2_in.data = 16'h0070;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) begin
      @(negedge clk);
      acc = p2_in.ready;
      @(posedge clk); #1;
    end
    p2_in.valid = 1'b0;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) begin
      @(negedge clk);
      acc = p2_out.valid;
      if (!acc) @(posedge clk);
    end
    check("stat_stall_seen", 32'(acc), 1);
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("stat_xfer", stat_xfer_cnt, 5);
    check("stat_stall", stat_stall_cnt, 7);
    @(posedge clk); #1;
    p2_out.ready = 1'b1;
    repeat (4) @(posedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
